// File: rtl/axi4_pkg.sv
// AXI4 read-channel structures shared by the core's memory-side blocks.
package axi4_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    typedef struct packed {
        logic              arvalid;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
    } ar_m;

    typedef struct packed {
        logic arready;
    } ar_s;

    typedef struct packed {
        logic rready;
    } r_m;

    typedef struct packed {
        logic              rvalid;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
    } r_s;

endpackage

// File: rtl/riscv_pkg.sv
// Core-level types for the read arbiter: order-FIFO entry, AR FSM states, grant helper.
package riscv_pkg;

    import axi4_pkg::*;

    typedef struct packed {
        logic            req;
        logic [ID_W-1:0] arid;
    } ord_entry_t;

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

    // On a conflict the requester that did not win last time is chosen.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        logic pick;
        if (valid == 2'b11) begin
            pick = ~last_grant;
        end else if (valid[0]) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/riscv_axi_rd_arb_chk.sv
// Protocol checks for the read arbiter, kept apart from the datapath.
module riscv_axi_rd_arb_chk (
    input logic       clock,
    input logic       reset,
    input logic       axi_rvalid,
    input logic       fifo_empty,
    input logic [1:0] req_arready
);

    // A beat with nothing outstanding has no owner and is dropped
    a_rvalid_without_burst: assert property (
        @(posedge clock) disable iff (reset) !(axi_rvalid && fifo_empty));

    a_single_grant: assert property (
        @(posedge clock) disable iff (reset) $onehot0(req_arready));

endmodule

// File: rtl/riscv_order_fifo.sv
// In-order FIFO remembering which requester owns each outstanding read burst.
module riscv_order_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ord_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == CNT_W'(0));
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_axi_rd_arb.sv
// Two-requester AXI read arbiter: round-robin AR issue with one held AR, in-order R routing.
module riscv_axi_rd_arb
    import axi4_pkg::*;
    import riscv_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  ar_m [1:0] REQ_AR_M,
    output ar_s [1:0] REQ_AR_S,
    input  r_m  [1:0] REQ_R_M,
    output r_s  [1:0] REQ_R_S,
    output ar_m       AXI_AR_M,
    input  ar_s       AXI_AR_S,
    output r_m        AXI_R_M,
    input  r_s        AXI_R_S,
    output logic      busy
);

    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    ar_state_e        state_r;
    ar_state_e        state_s;
    logic             last_grant_r;
    ar_m              hold_r;
    ar_m              cap_s;
    logic             grant_s;
    logic             ar_hs_s;
    logic [1:0]       req_valid_s;
    ord_entry_t       push_data_s;
    ord_entry_t       head_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;

    assign req_valid_s = {REQ_AR_M[1].arvalid, REQ_AR_M[0].arvalid};

    // Grant, upstream ARREADY and next-state decode
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        ar_hs_s     = 1'b0;
        cap_s       = '0;
        push_data_s = '0;
        REQ_AR_S    = '0;
        case (state_r)
            AR_IDLE: begin
                if (!full_s && (req_valid_s != 2'b00)) begin
                    grant_s                  = rr_pick(req_valid_s, last_grant_r);
                    ar_hs_s                  = 1'b1;
                    REQ_AR_S[grant_s].arready = 1'b1;
                    cap_s                    = REQ_AR_M[grant_s];
                    cap_s.arid               = '0;
                    cap_s.arvalid            = 1'b1;
                    push_data_s.req          = grant_s;
                    push_data_s.arid         = REQ_AR_M[grant_s].arid;
                    state_s                  = AR_HOLD;
                end else begin
                    state_s = AR_IDLE;
                end
            end
            AR_HOLD: begin
                if (AXI_AR_S.arready) begin
                    state_s = AR_IDLE;
                end else begin
                    state_s = AR_HOLD;
                end
            end
            default: state_s = AR_IDLE;
        endcase
    end

    // hold_r doubles as the downstream AR register; its arvalid tracks the HOLD state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= AR_IDLE;
            last_grant_r <= 1'b1;
            hold_r       <= '0;
        end else begin
            state_r <= state_s;
            if (ar_hs_s) begin
                last_grant_r <= grant_s;
                hold_r       <= cap_s;
            end else if ((state_r == AR_HOLD) && AXI_AR_S.arready) begin
                hold_r.arvalid <= 1'b0;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign AXI_AR_M = hold_r;

    // R beats go to the owner of the oldest outstanding burst, with its original ID
    always_comb begin
        REQ_R_S = '0;
        AXI_R_M = '0;
        pop_s   = 1'b0;
        if (!empty_s) begin
            REQ_R_S[head_s.req]     = AXI_R_S;
            REQ_R_S[head_s.req].rid = head_s.arid;
            AXI_R_M.rready          = REQ_R_M[head_s.req].rready;
            pop_s = AXI_R_S.rvalid && REQ_R_M[head_s.req].rready && AXI_R_S.rlast;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign busy = (count_s != CNT_W'(0)) || (state_r == AR_HOLD);

    riscv_order_fifo #(
        .DEPTH   (OUTSTANDING),
        .entry_t (ord_entry_t)
    ) u_order_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ar_hs_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    riscv_axi_rd_arb_chk u_chk (
        .clock       (clock),
        .reset       (reset),
        .axi_rvalid  (AXI_R_S.rvalid),
        .fifo_empty  (empty_s),
        .req_arready ({REQ_AR_S[1].arready, REQ_AR_S[0].arready})
    );

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Scoreboard bench for riscv_axi_rd_arb: directed AR/R traffic, monitor checks every handshake.
module tb_riscv_axi_rd_arb;

    import axi4_pkg::*;

    logic      clock = 1'b0;
    logic      reset;
    ar_m [1:0] REQ_AR_M;
    ar_s [1:0] REQ_AR_S;
    r_m  [1:0] REQ_R_M;
    r_s  [1:0] REQ_R_S;
    ar_m       AXI_AR_M;
    ar_s       AXI_AR_S;
    r_m        AXI_R_M;
    r_s        AXI_R_S;
    logic      busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_ar_t;

    typedef struct {
        int          req;
        logic [3:0]  rid;
        logic [31:0] data;
        logic        last;
    } exp_r_t;

    exp_ar_t exp_ar_q[$];
    exp_r_t  exp_r_q[$];

    riscv_axi_rd_arb #(.OUTSTANDING(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .REQ_AR_M (REQ_AR_M),
        .REQ_AR_S (REQ_AR_S),
        .REQ_R_M  (REQ_R_M),
        .REQ_R_S  (REQ_R_S),
        .AXI_AR_M (AXI_AR_M),
        .AXI_AR_S (AXI_AR_S),
        .AXI_R_M  (AXI_R_M),
        .AXI_R_S  (AXI_R_S),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic ar_m mk_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        ar_m a;
        a         = '0;
        a.arvalid = 1'b1;
        a.arid    = id;
        a.araddr  = addr;
        a.arlen   = len;
        a.arsize  = 3'd2;
        a.arburst = 2'b01;
        return a;
    endfunction

    function automatic r_s mk_r(input logic [31:0] data, input logic last);
        r_s b;
        b        = '0;
        b.rvalid = 1'b1;
        b.rid    = 4'hF;
        b.rdata  = data;
        b.rlast  = last;
        return b;
    endfunction

    // Hold ARVALID until the arbiter grants this requester (bounded)
    task automatic issue_ar(input int r, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        bit done;
        done = 1'b0;
        exp_ar_q.push_back('{addr, len});
        REQ_AR_M[r] = mk_ar(addr, id, len);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (REQ_AR_S[r].arready) done = 1'b1;
            tick();
        end
        chk("ar_accept", 64'(done), 64'd1);
        REQ_AR_M[r].arvalid = 1'b0;
    endtask

    // Present one downstream beat until RREADY (bounded); RID F must be replaced
    task automatic send_r(input int req, input logic [3:0] rid, input logic [31:0] data, input logic last);
        bit done;
        done = 1'b0;
        exp_r_q.push_back('{req, rid, data, last});
        AXI_R_S = mk_r(data, last);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (AXI_R_M.rready) done = 1'b1;
            tick();
        end
        chk("r_accept", 64'(done), 64'd1);
        AXI_R_S = '0;
    endtask

    // Monitor: compare every downstream AR and upstream R handshake with the scoreboard
    initial begin
        exp_ar_t ea;
        exp_r_t  er;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (AXI_AR_M.arvalid && AXI_AR_S.arready) begin
                    if (exp_ar_q.size() == 0) begin
                        chk("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        ea = exp_ar_q.pop_front();
                        chk("ar_addr", 64'(AXI_AR_M.araddr), 64'(ea.addr));
                        chk("ar_len", 64'(AXI_AR_M.arlen), 64'(ea.len));
                        chk("ar_id", 64'(AXI_AR_M.arid), 64'd0);
                    end
                end
                if (REQ_R_S[0].rvalid || REQ_R_S[1].rvalid) begin
                    chk("r_onehot", 64'(REQ_R_S[0].rvalid && REQ_R_S[1].rvalid), 64'd0);
                end
                for (int i = 0; i < 2; i++) begin
                    if (REQ_R_S[i].rvalid && REQ_R_M[i].rready) begin
                        if (exp_r_q.size() == 0) begin
                            chk("r_unexpected", 64'd1, 64'd0);
                        end else begin
                            er = exp_r_q.pop_front();
                            chk("r_req", 64'(i), 64'(er.req));
                            chk("r_rid", 64'(REQ_R_S[i].rid), 64'(er.rid));
                            chk("r_data", 64'(REQ_R_S[i].rdata), 64'(er.data));
                            chk("r_last", 64'(REQ_R_S[i].rlast), 64'(er.last));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        REQ_AR_M = '0;
        REQ_R_M  = '0;
        AXI_AR_S = '0;
        AXI_R_S  = '0;
        reset    = 1'b1;
        REQ_R_M[0].rready = 1'b1;
        REQ_R_M[1].rready = 1'b1;
        AXI_AR_S.arready  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state: nothing valid, nothing ready, not busy
        @(negedge clock);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_arvalid", 64'(AXI_AR_M.arvalid), 64'd0);
        chk("reset_arready", 64'({REQ_AR_S[1].arready, REQ_AR_S[0].arready}), 64'd0);
        chk("reset_rvalid", 64'({REQ_R_S[1].rvalid, REQ_R_S[0].rvalid}), 64'd0);
        chk("reset_rready", 64'(AXI_R_M.rready), 64'd0);

        // Conflict right after reset: requester 0 first, then requester 1
        exp_ar_q.push_back('{32'h1000, 8'd0});
        exp_ar_q.push_back('{32'h2000, 8'd0});
        REQ_AR_M[0] = mk_ar(32'h1000, 4'h2, 8'd0);
        REQ_AR_M[1] = mk_ar(32'h2000, 4'h7, 8'd0);
        #1;
        chk("rr_first_req0", 64'(REQ_AR_S[0].arready), 64'd1);
        chk("rr_first_req1", 64'(REQ_AR_S[1].arready), 64'd0);
        tick();
        REQ_AR_M[0].arvalid = 1'b0;
        @(negedge clock);
        chk("hold_refuse", 64'(REQ_AR_S[1].arready), 64'd0);
        tick();
        @(negedge clock);
        chk("rr_second_req1", 64'(REQ_AR_S[1].arready), 64'd1);
        tick();
        REQ_AR_M[1].arvalid = 1'b0;
        tick();
        send_r(0, 4'h2, 32'hA0A0_0001, 1'b1);
        send_r(1, 4'h7, 32'hB0B0_0001, 1'b1);

        // Four-beat burst to requester 1 with ID 5, first beat back-pressured upstream
        issue_ar(1, 32'h3000, 4'h5, 8'd3);
        tick();
        REQ_R_M[1].rready = 1'b0;
        AXI_R_S = mk_r(32'h3000_0000, 1'b0);
        @(negedge clock);
        chk("bp_axi_rready", 64'(AXI_R_M.rready), 64'd0);
        chk("bp_rvalid1", 64'(REQ_R_S[1].rvalid), 64'd1);
        chk("bp_rid", 64'(REQ_R_S[1].rid), 64'd5);
        tick();
        REQ_R_M[1].rready = 1'b1;
        AXI_R_S = '0;
        for (int b = 0; b < 4; b++) begin
            send_r(1, 4'h5, 32'h3000_0000 + 32'(b), (b == 3));
        end

        // Downstream stalls: held AR stays stable, upstream refused
        AXI_AR_S.arready = 1'b0;
        issue_ar(0, 32'h4000, 4'h1, 8'd1);
        REQ_AR_M[1] = mk_ar(32'h5000, 4'h3, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("stall_arvalid", 64'(AXI_AR_M.arvalid), 64'd1);
            chk("stall_araddr", 64'(AXI_AR_M.araddr), 64'h4000);
            chk("stall_arlen", 64'(AXI_AR_M.arlen), 64'd1);
            chk("stall_arid", 64'(AXI_AR_M.arid), 64'd0);
            chk("stall_up_arready", 64'(REQ_AR_S[1].arready), 64'd0);
            tick();
        end
        REQ_AR_M[1].arvalid = 1'b0;
        AXI_AR_S.arready = 1'b1;
        tick();
        send_r(0, 4'h1, 32'h4000_0000, 1'b0);
        send_r(0, 4'h1, 32'h4000_0001, 1'b1);

        // Fill all four slots; fifth AR waits until the cycle after the first pop
        for (int i = 0; i < 4; i++) begin
            issue_ar(0, 32'h6000 + 32'(i * 16), 4'(i), 8'd0);
        end
        tick();
        exp_ar_q.push_back('{32'h7000, 8'd0});
        REQ_AR_M[1] = mk_ar(32'h7000, 4'h9, 8'd0);
        @(negedge clock);
        chk("full_busy", 64'(busy), 64'd1);
        chk("full_refuse", 64'(REQ_AR_S[1].arready), 64'd0);
        tick();
        exp_r_q.push_back('{0, 4'h0, 32'h6000_0000, 1'b1});
        AXI_R_S = mk_r(32'h6000_0000, 1'b1);
        @(negedge clock);
        chk("pop_cycle_refuse", 64'(REQ_AR_S[1].arready), 64'd0);
        chk("pop_cycle_rready", 64'(AXI_R_M.rready), 64'd1);
        tick();
        AXI_R_S = '0;
        @(negedge clock);
        chk("after_pop_accept", 64'(REQ_AR_S[1].arready), 64'd1);
        tick();
        REQ_AR_M[1].arvalid = 1'b0;
        tick();

        // Pop coinciding with a new push keeps count and order
        send_r(0, 4'h1, 32'h6000_0001, 1'b1);
        exp_ar_q.push_back('{32'h8000, 8'd0});
        exp_r_q.push_back('{0, 4'h2, 32'h6000_0002, 1'b1});
        REQ_AR_M[0] = mk_ar(32'h8000, 4'hA, 8'd0);
        AXI_R_S = mk_r(32'h6000_0002, 1'b1);
        @(negedge clock);
        chk("coinc_arready", 64'(REQ_AR_S[0].arready), 64'd1);
        chk("coinc_rready", 64'(AXI_R_M.rready), 64'd1);
        tick();
        REQ_AR_M[0].arvalid = 1'b0;
        AXI_R_S = '0;
        tick();
        send_r(0, 4'h3, 32'h6000_0003, 1'b1);
        send_r(1, 4'h9, 32'h7000_0000, 1'b1);
        @(negedge clock);
        chk("coinc_busy_last", 64'(busy), 64'd1);
        tick();
        send_r(0, 4'hA, 32'h8000_0000, 1'b1);
        @(negedge clock);
        chk("drained_busy", 64'(busy), 64'd0);
        tick();

        // Reset in the middle of a burst with two bursts outstanding
        issue_ar(0, 32'h9000, 4'h3, 8'd1);
        issue_ar(1, 32'hA000, 4'h4, 8'd1);
        tick();
        send_r(0, 4'h3, 32'h9000_0000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_arvalid", 64'(AXI_AR_M.arvalid), 64'd0);
        chk("midrst_rvalid", 64'({REQ_R_S[1].rvalid, REQ_R_S[0].rvalid}), 64'd0);
        chk("midrst_rready", 64'(AXI_R_M.rready), 64'd0);
        tick();
        issue_ar(1, 32'hB000, 4'h6, 8'd0);
        tick();
        @(negedge clock);
        chk("fresh_busy", 64'(busy), 64'd1);
        tick();
        send_r(1, 4'h6, 32'hB000_0000, 1'b1);
        @(negedge clock);
        chk("fresh_idle", 64'(busy), 64'd0);

        chk("ar_queue_empty", 64'(exp_ar_q.size()), 64'd0);
        chk("r_queue_empty", 64'(exp_r_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
